pool_layer_scheduler: RTL and testbench
=======================================

Name: pool_layer_scheduler

Overview:
- Sequences a single clocked max-pooling engine across an entire feature-map layer (multiple channels, non-overlapping windows, stride = window size).
- Accepts one layer configuration and walks every output position in raster order, channel-major.
- For each position: issues a window job to the engine, waits for its done, then writes the pooled value to output memory.
- Sits between the layer-level CNN controller and the pooling engine / output feature buffer.

Parameters:
- DATA_W, 16, pixel/result width (signed fixed point).
- ADDR_W, 10, feature-memory address width (1024 words).
- DIM_W, 16, width of the size, window and channel config fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_valid  in  1  layer config offered.
- cfg_ready  out  1  scheduler idle; config accepted when cfg_valid && cfg_ready.
- cfg_img_size  in  DIM_W  input map side length N (square).
- cfg_win_size  in  DIM_W  window side length W.
- cfg_num_ch  in  DIM_W  channel count C.
- cfg_err  out  1  one-cycle pulse: config rejected.
- eng_start  out  1  one-cycle pulse: engine starts a window.
- eng_base_addr  out  ADDR_W  top-left input address of the window.
- eng_img_size  out  DIM_W  N forwarded to the engine.
- eng_win_size  out  DIM_W  W forwarded to the engine.
- eng_done  in  1  engine result valid (single-cycle pulse).
- eng_result  in  DATA_W  pooled value.
- out_wr_en  out  1  output memory write strobe.
- out_wr_addr  out  ADDR_W  output address.
- out_wr_data  out  DATA_W  value written.
- busy  out  1  layer in progress.
- layer_done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset, while reset=0 (asynchronous): state IDLE, all counters 0, cfg_ready=1, all other outputs 0.
- Config validation on acceptance:
  - Reject if W=0, W>N, C=0, or C*N*N > 2^ADDR_W.
  - Rejection: cfg_err pulses in the cycle after acceptance; state stays IDLE; no eng_start.
- Valid config:
  - Latch N, W, C and compute M = floor(N/W); remainder rows/cols are dropped.
  - Go to ISSUE on the next cycle; cfg_ready=0 and busy=1 until DONE exits.
- FSM:
  - IDLE --valid cfg--> ISSUE.
  - ISSUE: eng_start=1 for one cycle; eng_base_addr/eng_img_size/eng_win_size stay valid and stable until eng_done. --> WAIT.
  - WAIT: hold until eng_done=1. On eng_done, register eng_result. --> WRITE.
  - WRITE: out_wr_en=1 for one cycle, with out_wr_addr and out_wr_data. If last position of last channel --> DONE, else advance counters --> ISSUE.
  - DONE: layer_done=1 for one cycle --> IDLE (cfg_ready=1 again).
- Addressing (incremental adders only, no multipliers in the walk loop):
  - base = ch_base + row_base + col_off.
  - col_off += W per output column.
  - At column wrap: col_off=0, row_base += W*N.
  - At row wrap: row_base=0, ch_base += N*N.
  - out_wr_addr starts at 0 and increments by 1 per write, giving the dense C x M x M layout.
  - The latch-time products W*N and N*N may be computed in IDLE/accept with a single multiply.
- Throughput: 3 scheduler cycles per window plus engine latency; eng_done is never required in the same cycle as eng_start.
- Error conditions:
  - eng_done outside WAIT is ignored.
  - cfg_valid while busy is ignored (cfg_ready=0).
- Reset mid-layer: abort immediately. No layer_done and no further writes; a write asserted in the reset cycle is suppressed by the asynchronous clear.
- All address arithmetic is unsigned, truncated to ADDR_W. Validation guarantees no overflow.

Decomposition:
- Shared package `cnn_pkg`:
  - DATA_W, ADDR_W, DIM_W defaults.
  - Enum `pool_sched_state_t` {IDLE, ISSUE, WAIT, WRITE, DONE}.
- One sub-module, `pool_addr_gen`: the row/col/channel counters, base-address adders and last-position flag. The FSM instantiates it, drives its `clear` and `step` inputs, and reads its `base`, `out_addr` and `last` outputs.

Test Plan:
- N=10, W=5, C=1; engine stub returns 0x0400 after 4 cycles -> eng_base_addr sequence 0,5,50,55; writes to addresses 0..3 with 0x0400; one layer_done; busy low afterwards.
- N=10, W=3, C=1 -> M=3; bases 0,3,6,30,33,36,60,63,66; 9 writes; row/col 9 never addressed.
- N=4, W=2, C=2 -> 8 windows; channel-1 bases 16,18,24,26; out_wr_addr 4..7 for channel 1.
- Configs W=0, then W=11 with N=10, then C=0 -> each gives a cfg_err pulse, no eng_start, cfg_ready stays 1.
- Assert reset=0 during WAIT of window 2 in the N=10, W=5 run -> outputs cleared asynchronously, no layer_done. A fresh config afterwards restarts at base 0.
- Spurious eng_done during ISSUE, and cfg_valid while busy -> both ignored; write count and addresses unchanged from the first scenario.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer controllers.
// Holds the default datapath widths used by the pooling scheduler and the
// state encoding of its sequencing FSM.
package cnn_pkg;

    localparam int DATA_W_DEFAULT = 16;  // pixel / pooled result width
    localparam int ADDR_W_DEFAULT = 10;  // feature memory address width
    localparam int DIM_W_DEFAULT  = 16;  // size / window / channel fields

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } pool_sched_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window address walker for the pooling scheduler.
// Tracks the column / row / channel position of the current output pixel and
// produces the top-left input address of its window using adders only.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clear          restart the walk at position 0 (layer accept)
//   step           advance to the next output position
//   img_size       N, input map side
//   win_size       W, window side (also the stride)
//   num_ch         C, channel count
//   row_step       W*N, address distance between window rows
//   ch_step        N*N, address distance between channels
//   base           input address of the current window
//   out_addr       dense output address of the current position
//   last           current position is the final one of the layer
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DIM_W  = DIM_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [DIM_W-1:0]  img_size,
    input  logic [DIM_W-1:0]  win_size,
    input  logic [DIM_W-1:0]  num_ch,
    input  logic [ADDR_W-1:0] row_step,
    input  logic [ADDR_W-1:0] ch_step,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] out_addr,
    output logic              last
);

    logic [DIM_W-1:0]  col_pos, row_pos, ch_cnt;
    logic [ADDR_W-1:0] col_off, row_base, ch_base;

    logic [DIM_W-1:0]  col_pos_n, row_pos_n, ch_cnt_n;
    logic [ADDR_W-1:0] col_off_n, row_base_n, ch_base_n;

    logic [DIM_W+1:0]  col_reach, row_reach;
    logic              col_last, row_last, ch_last;
    logic [ADDR_W-1:0] win_addr;

    assign win_addr = win_size[ADDR_W-1:0];

    // A further window fits only if it ends inside the map; the check
    // "pos + 2W > N" replaces a division computing M = floor(N/W), and
    // silently drops the remainder rows/columns.
    assign col_reach = (DIM_W+2)'(col_pos) + (DIM_W+2)'(win_size) + (DIM_W+2)'(win_size);
    assign row_reach = (DIM_W+2)'(row_pos) + (DIM_W+2)'(win_size) + (DIM_W+2)'(win_size);
    assign col_last  = col_reach > (DIM_W+2)'(img_size);
    assign row_last  = row_reach > (DIM_W+2)'(img_size);
    assign ch_last   = (ch_cnt == num_ch - DIM_W'(1));
    assign last      = col_last && row_last && ch_last;

    always_comb begin
        col_pos_n  = col_pos + win_size;
        col_off_n  = col_off + win_addr;
        row_pos_n  = row_pos;
        row_base_n = row_base;
        ch_cnt_n   = ch_cnt;
        ch_base_n  = ch_base;
        if (col_last) begin
            col_pos_n  = '0;
            col_off_n  = '0;
            row_pos_n  = row_pos + win_size;
            row_base_n = row_base + row_step;
            if (row_last) begin
                row_pos_n  = '0;
                row_base_n = '0;
                ch_cnt_n   = ch_cnt + DIM_W'(1);
                ch_base_n  = ch_base + ch_step;
            end
        end
    end

    // base is kept as its own register so the engine sees a stable,
    // glitch-free address for the whole window job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_pos  <= '0;
            row_pos  <= '0;
            ch_cnt   <= '0;
            col_off  <= '0;
            row_base <= '0;
            ch_base  <= '0;
            base     <= '0;
            out_addr <= '0;
        end else if (clear) begin
            col_pos  <= '0;
            row_pos  <= '0;
            ch_cnt   <= '0;
            col_off  <= '0;
            row_base <= '0;
            ch_base  <= '0;
            base     <= '0;
            out_addr <= '0;
        end else if (step) begin
            col_pos  <= col_pos_n;
            row_pos  <= row_pos_n;
            ch_cnt   <= ch_cnt_n;
            col_off  <= col_off_n;
            row_base <= row_base_n;
            ch_base  <= ch_base_n;
            base     <= ch_base_n + row_base_n + col_off_n;
            out_addr <= out_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/pool_layer_scheduler.sv
// Layer-level sequencer for a single max-pooling engine.
// Accepts one layer configuration, then for every output position (raster
// order, channel-major) issues a window job, waits for the engine result and
// writes it to the dense C x M x M output buffer.
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   cfg_valid/cfg_ready              layer configuration handshake
//   cfg_img_size/win_size/num_ch     N, W, C
//   cfg_err                          pulse: configuration rejected
//   eng_start                        pulse: start a window job
//   eng_base_addr/img_size/win_size  window job parameters
//   eng_done/eng_result              engine completion and pooled value
//   out_wr_en/addr/data              output buffer write port
//   busy                             layer in progress
//   layer_done                       pulse after the final write
module pool_layer_scheduler
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DIM_W  = DIM_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIM_W-1:0]  cfg_img_size,
    input  logic [DIM_W-1:0]  cfg_win_size,
    input  logic [DIM_W-1:0]  cfg_num_ch,
    output logic              cfg_err,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_base_addr,
    output logic [DIM_W-1:0]  eng_img_size,
    output logic [DIM_W-1:0]  eng_win_size,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_result,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [DATA_W-1:0] out_wr_data,
    output logic              busy,
    output logic              layer_done
);

    localparam logic [3*DIM_W-1:0] MEM_WORDS = (3*DIM_W)'(1) << ADDR_W;

    pool_sched_state_t state;

    logic [DIM_W-1:0]   n_q, w_q, c_q;
    logic [ADDR_W-1:0]  row_step_q, ch_step_q;

    logic [2*DIM_W-1:0] map_words;
    logic [3*DIM_W-1:0] layer_words;
    logic [ADDR_W-1:0]  row_step_calc;
    logic               cfg_bad;
    logic               gen_clear, gen_step, gen_last;

    // Accept-time arithmetic: full-width products so an oversized layer is
    // caught before any address could wrap.
    assign map_words     = (2*DIM_W)'(cfg_img_size) * (2*DIM_W)'(cfg_img_size);
    assign layer_words   = (3*DIM_W)'(cfg_num_ch) * (3*DIM_W)'(map_words);
    assign row_step_calc = cfg_win_size[ADDR_W-1:0] * cfg_img_size[ADDR_W-1:0];

    assign cfg_bad = (cfg_win_size == '0) || (cfg_win_size > cfg_img_size) ||
                     (cfg_num_ch == '0) || (layer_words > MEM_WORDS);

    assign gen_clear = (state == IDLE) && cfg_valid && !cfg_bad;
    assign gen_step  = (state == WRITE) && !gen_last;

    assign eng_img_size = n_q;
    assign eng_win_size = w_q;

    pool_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (gen_clear),
        .step     (gen_step),
        .img_size (n_q),
        .win_size (w_q),
        .num_ch   (c_q),
        .row_step (row_step_q),
        .ch_step  (ch_step_q),
        .base     (eng_base_addr),
        .out_addr (out_wr_addr),
        .last     (gen_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            eng_start   <= 1'b0;
            out_wr_en   <= 1'b0;
            out_wr_data <= '0;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            n_q         <= '0;
            w_q         <= '0;
            c_q         <= '0;
            row_step_q  <= '0;
            ch_step_q   <= '0;
        end else begin
            cfg_err    <= 1'b0;
            eng_start  <= 1'b0;
            out_wr_en  <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            n_q        <= cfg_img_size;
                            w_q        <= cfg_win_size;
                            c_q        <= cfg_num_ch;
                            row_step_q <= row_step_calc;
                            ch_step_q  <= map_words[ADDR_W-1:0];
                            cfg_ready  <= 1'b0;
                            busy       <= 1'b1;
                            eng_start  <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        out_wr_data <= eng_result;
                        out_wr_en   <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (gen_last) begin
                        layer_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_layer_scheduler.sv
module tb_pool_layer_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_img_size = '0;
    logic [15:0] cfg_win_size = '0;
    logic [15:0] cfg_num_ch = '0;
    logic        cfg_err;
    logic        eng_start;
    logic [9:0]  eng_base_addr;
    logic [15:0] eng_img_size;
    logic [15:0] eng_win_size;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        out_wr_en;
    logic [9:0]  out_wr_addr;
    logic [15:0] out_wr_data;
    logic        busy;
    logic        layer_done;

    logic        stub_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] eng_val = '0;
    int          cd = 0;

    int passed = 0;
    int total  = 0;

    int base_log [64];
    int wr_addr_log [64];
    int wr_data_log [64];
    int base_n = 0, wr_n = 0, done_n = 0, err_n = 0;
    int exp_b[$];

    assign eng_done   = stub_done | spur_done;
    assign eng_result = eng_val;

    always #5 clk = ~clk;

    pool_layer_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_img_size  (cfg_img_size),
        .cfg_win_size  (cfg_win_size),
        .cfg_num_ch    (cfg_num_ch),
        .cfg_err       (cfg_err),
        .eng_start     (eng_start),
        .eng_base_addr (eng_base_addr),
        .eng_img_size  (eng_img_size),
        .eng_win_size  (eng_win_size),
        .eng_done      (eng_done),
        .eng_result    (eng_result),
        .out_wr_en     (out_wr_en),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data),
        .busy          (busy),
        .layer_done    (layer_done)
    );

    // Engine stub: result 4 cycles after eng_start, single-cycle done.
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (!reset) cd = 0;
        else if (eng_start) cd = 4;
        else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) stub_done = 1'b1;
        end
    end

    // Event logger.
    always @(negedge clk) begin
        if (eng_start) begin
            if (base_n < 64) base_log[base_n] = int'(eng_base_addr);
            base_n++;
        end
        if (out_wr_en) begin
            if (wr_n < 64) begin
                wr_addr_log[wr_n] = int'(out_wr_addr);
                wr_data_log[wr_n] = int'(out_wr_data);
            end
            wr_n++;
        end
        if (layer_done) done_n++;
        if (cfg_err) err_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_cfg(input int n, input int w, input int c);
        @(negedge clk);
        cfg_valid    = 1'b1;
        cfg_img_size = 16'(n);
        cfg_win_size = 16'(w);
        cfg_num_ch   = 16'(c);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
    endtask

    task automatic wait_layer(input string tag, input int target);
        int k = 0;
        while (done_n < target && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_timeout"}, 32'(done_n >= target), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int b0, input int w0, input int d0,
                          input logic [15:0] data);
        int nexp = exp_b.size();
        chk({tag, "_starts"}, 32'(base_n - b0), 32'(nexp));
        chk({tag, "_writes"}, 32'(wr_n - w0), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (b0 + i < 64 && w0 + i < 64) begin
                chk($sformatf("%s_base%0d", tag, i), 32'(base_log[b0 + i]), 32'(exp_b[i]));
                chk($sformatf("%s_waddr%0d", tag, i), 32'(wr_addr_log[w0 + i]), 32'(i));
                chk($sformatf("%s_wdata%0d", tag, i), 32'(wr_data_log[w0 + i]), 32'(data));
            end
        end
        chk({tag, "_done_cnt"}, 32'(done_n - d0), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int b0, w0, d0, e0;

        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_ldone", 32'(layer_done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // N=10 W=5 C=1
        eng_val = 16'h0400;
        exp_b = '{0, 5, 50, 55};
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(10, 5, 1);
        chk("s1_busy_run", 32'(busy), 32'd1);
        chk("s1_ready_run", 32'(cfg_ready), 32'd0);
        wait_layer("s1", d0 + 1);
        verify("s1", b0, w0, d0, 16'h0400);

        // N=10 W=3 C=1: M=3, remainder row/col dropped
        eng_val = 16'hFF9C;
        exp_b = '{0, 3, 6, 30, 33, 36, 60, 63, 66};
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(10, 3, 1);
        wait_layer("s2", d0 + 1);
        verify("s2", b0, w0, d0, 16'hFF9C);
        chk("s2_eng_img", 32'(eng_img_size), 32'd10);
        chk("s2_eng_win", 32'(eng_win_size), 32'd3);

        // N=4 W=2 C=2: channel 1 starts at 16
        eng_val = 16'h1234;
        exp_b = '{0, 2, 8, 10, 16, 18, 24, 26};
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(4, 2, 2);
        wait_layer("s3", d0 + 1);
        verify("s3", b0, w0, d0, 16'h1234);

        // Largest legal layer: C*N*N == 1024, one 32x32 window
        eng_val = 16'h8001;
        exp_b = '{0};
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(32, 32, 1);
        wait_layer("s4", d0 + 1);
        verify("s4", b0, w0, d0, 16'h8001);

        // Rejected configs: W=0, W>N, C=0, C*N*N above memory (two cases)
        b0 = base_n; e0 = err_n; d0 = done_n;
        send_cfg(10, 0, 1);
        chk("err_w0_pulse", 32'(cfg_err), 32'd1);
        chk("err_w0_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk); #1;
        chk("err_w0_one_cycle", 32'(cfg_err), 32'd0);
        send_cfg(10, 11, 1);
        chk("err_wbig_pulse", 32'(cfg_err), 32'd1);
        send_cfg(10, 5, 0);
        chk("err_c0_pulse", 32'(cfg_err), 32'd1);
        send_cfg(33, 1, 1);
        chk("err_n33_pulse", 32'(cfg_err), 32'd1);
        send_cfg(16, 16, 5);
        chk("err_c5_pulse", 32'(cfg_err), 32'd1);
        repeat (8) @(negedge clk);
        #1;
        chk("err_count", 32'(err_n - e0), 32'd5);
        chk("err_no_start", 32'(base_n - b0), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_ready", 32'(cfg_ready), 32'd1);
        chk("err_no_done", 32'(done_n - d0), 32'd0);

        // Spurious eng_done during ISSUE and a config offered while busy
        eng_val = 16'h0400;
        exp_b = '{0, 5, 50, 55};
        b0 = base_n; w0 = wr_n; d0 = done_n; e0 = err_n;
        send_cfg(10, 5, 1);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done    = 1'b0;
        cfg_valid    = 1'b1;
        cfg_img_size = 16'd4;
        cfg_win_size = 16'd2;
        cfg_num_ch   = 16'd2;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0;
        wait_layer("s5", d0 + 1);
        verify("s5", b0, w0, d0, 16'h0400);
        chk("s5_no_err", 32'(err_n - e0), 32'd0);

        // Reset during WAIT of window 2, then a fresh layer
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(10, 5, 1);
        begin
            int k = 0;
            while (base_n < b0 + 2 && k < 200) begin
                @(negedge clk); #1; k++;
            end
            chk("rst_mid_reach_w2", 32'(base_n - b0), 32'd2);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(cfg_ready), 32'd1);
        chk("rstmid_start", 32'(eng_start), 32'd0);
        chk("rstmid_wr_en", 32'(out_wr_en), 32'd0);
        chk("rstmid_base", 32'(eng_base_addr), 32'd0);
        chk("rstmid_waddr", 32'(out_wr_addr), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rstmid_writes", 32'(wr_n - w0), 32'd1);
        chk("rstmid_no_done", 32'(done_n - d0), 32'd0);
        chk("rstmid_starts", 32'(base_n - b0), 32'd2);

        eng_val = 16'h0077;
        exp_b = '{0, 5, 50, 55};
        b0 = base_n; w0 = wr_n; d0 = done_n;
        send_cfg(10, 5, 1);
        wait_layer("s6", d0 + 1);
        verify("s6", b0, w0, d0, 16'h0077);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
